bcd_display_encoder: RTL

//   Converts a signed binary value into per-digit 5-bit display codes for a row of seven_seg

---
 rtl/bcd_display_encoder_pkg.sv | 42 ++++
 rtl/bcd_display_encoder_double_dabble.sv | 42 ++++
 rtl/bcd_display_encoder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bcd_display_encoder_pkg.sv
// Shared display-code encodings, FSM states and sizing helper for the BCD display encoder.
// Every module that produces or consumes per-digit display codes imports this package.
package bcd_display_encoder_pkg;

    localparam logic [4:0] BCD_0     = 5'd0;
    localparam logic [4:0] BCD_1     = 5'd1;
    localparam logic [4:0] BCD_2     = 5'd2;
    localparam logic [4:0] BCD_3     = 5'd3;
    localparam logic [4:0] BCD_4     = 5'd4;
    localparam logic [4:0] BCD_5     = 5'd5;
    localparam logic [4:0] BCD_6     = 5'd6;
    localparam logic [4:0] BCD_7     = 5'd7;
    localparam logic [4:0] BCD_8     = 5'd8;
    localparam logic [4:0] BCD_9     = 5'd9;
    localparam logic [4:0] BCD_A     = 5'd10;
    localparam logic [4:0] BCD_B     = 5'd11;
    localparam logic [4:0] BCD_C     = 5'd12;
    localparam logic [4:0] BCD_D     = 5'd13;
    localparam logic [4:0] BCD_E     = 5'd14;
    localparam logic [4:0] BCD_F     = 5'd15;
    localparam logic [4:0] BCD_G     = 5'd16;
    localparam logic [4:0] BCD_L     = 5'd17;
    localparam logic [4:0] BCD_N     = 5'd18;
    localparam logic [4:0] BCD_O     = 5'd19;
    localparam logic [4:0] BCD_R     = 5'd20;
    localparam logic [4:0] BCD_T     = 5'd21;
    localparam logic [4:0] BCD_NEG   = 5'd22;
    localparam logic [4:0] BCD_BLANK = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FORMAT = 2'd3
    } state_t;

    // Decimal digits needed for a WIDTH-bit magnitude (log10(2) ~ 0.301).
    function automatic int bcd_digits(input int width);
        return (width * 301) / 1000 + 1;
    endfunction

endpackage

// File: rtl/bcd_display_encoder_double_dabble.sv
// Shift-and-add-3 binary to BCD engine: load a magnitude, then one step per input bit.
// After WIDTH steps the bcd output holds the decimal digits of the loaded magnitude.
module double_dabble
    import bcd_display_encoder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NBCD  = bcd_digits(WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [WIDTH-1:0]    mag,
    input  logic                step,
    output logic [4*NBCD-1:0]   bcd
);

    logic [WIDTH-1:0]  mag_sr;
    logic [4*NBCD-1:0] adj;

    // Nibbles of 5 or more get +3 so the following shift carries correctly into the next digit.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < NBCD; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd    <= '0;
            mag_sr <= '0;
        end else if (load) begin
            bcd    <= '0;
            mag_sr <= mag;
        end else if (step) begin
            {bcd, mag_sr} <= {adj, mag_sr} << 1;
        end
    end

endmodule

// File: rtl/bcd_display_encoder.sv
// Signed binary to per-digit seven-segment codes with leading-zero blanking,
// a minus sign next to the leading digit, and "Err" when the value does not fit.
module bcd_display_encoder
    import bcd_display_encoder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [5*DIGITS-1:0]   codes,
    output logic [DIGITS-1:0]     disp_en
);

    localparam int NBCD  = bcd_digits(WIDTH);
    localparam int MAXD  = (DIGITS > NBCD) ? DIGITS : NBCD;
    localparam int CNT_W = $clog2(WIDTH);

    state_t              state, state_next;
    logic [WIDTH-1:0]    value_reg;
    logic                sign;
    logic [CNT_W-1:0]    bit_cnt;
    logic                dd_load;
    logic                dd_step;
    logic [WIDTH-1:0]    mag;
    logic [4*NBCD-1:0]   bcd;
    logic [4*MAXD-1:0]   bcd_pad;
    logic [5*DIGITS-1:0] codes_next;
    int                  msd;
    int                  avail;
    logic                neg;
    logic                overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dd_load    = 1'b0;
        dd_step    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dd_load    = 1'b1;
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                dd_step = 1'b1;
                if (bit_cnt == '0) begin
                    state_next = ST_FORMAT;
                end
            end
            ST_FORMAT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    // Unsigned negation: the most negative input maps to 2^(WIDTH-1) without wrapping.
    assign mag = sign ? ((~value_reg) + WIDTH'(1)) : value_reg;

    double_dabble #(
        .WIDTH (WIDTH),
        .NBCD  (NBCD)
    ) u_double_dabble (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (dd_load),
        .mag   (mag),
        .step  (dd_step),
        .bcd   (bcd)
    );

    always_comb begin
        bcd_pad                 = '0;
        bcd_pad[4*NBCD-1:0]     = bcd;
        msd                     = 0;
        for (int i = 0; i < MAXD; i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        neg      = sign && (bcd != '0);
        avail    = sign ? (DIGITS - 1) : DIGITS;
        overflow = (msd >= avail);
        codes_next = '0;
        for (int i = 0; i < DIGITS; i++) begin
            codes_next[5*i +: 5] = BCD_BLANK;
            if (overflow) begin
                if (i == 2) begin
                    codes_next[5*i +: 5] = BCD_E;
                end else if (i < 2) begin
                    codes_next[5*i +: 5] = BCD_R;
                end
            end else if (i <= msd) begin
                codes_next[5*i +: 5] = {1'b0, bcd_pad[4*i +: 4]};
            end else if (neg && (i == msd + 1)) begin
                codes_next[5*i +: 5] = BCD_NEG;
            end
        end
    end

    // Displays only change in the FORMAT cycle, so no partial result is ever shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= '0;
            sign      <= 1'b0;
            bit_cnt   <= '0;
            done      <= 1'b0;
            codes     <= {DIGITS{BCD_BLANK}};
            disp_en   <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE && start) begin
                value_reg <= value;
                sign      <= value[WIDTH-1];
            end
            if (state == ST_LOAD) begin
                bit_cnt <= CNT_W'(WIDTH - 1);
            end
            if (state == ST_SHIFT) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (state == ST_FORMAT) begin
                codes   <= codes_next;
                disp_en <= '1;
                done    <= 1'b1;
            end
        end
    end

endmodule
